// File: rtl/mem_port1_arbiter.sv
// rtl/mem_port1_arbiter.sv - port-1 arbiter: fixed priority to m0, starvation-forced grant to m1
module mem_port1_arbiter #(
  parameter int ADR_WIDTH  = 16,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADR_WIDTH-1:0]  m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADR_WIDTH-1:0]  m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_we,
  output logic [ADR_WIDTH-1:0]  mem_adr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m1_starved
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  m0_rvalid_q, m0_rvalid_d;
  logic                  m1_rvalid_q, m1_rvalid_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  starve, m0_win, m1_win;

  always_comb begin
    starve     = (wait_cnt_q == MAX_WAIT_C);
    m1_win     = m1_req && (!m0_req || starve);
    m0_win     = m0_req && !m1_win;
    m0_gnt     = m0_win && !rst;
    m1_gnt     = m1_win && !rst;
    // With no winner the m0 fields are driven; mem_we stays low anyway.
    mem_adr    = m1_win ? m1_adr : m0_adr;
    mem_wdata  = m1_win ? m1_wdata : m0_wdata;
    mem_we     = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    m1_starved = starve && m1_req;

    // A pulse pending from the cycle before reset is suppressed.
    m0_rvalid  = m0_rvalid_q && !rst;
    m1_rvalid  = m1_rvalid_q && !rst;
    m0_rdata   = m0_rdata_q;
    m1_rdata   = m1_rdata_q;

    wait_cnt_d = 4'd0;
    if (m1_req && !m1_gnt) begin
      wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
    end

    m0_rvalid_d = m0_gnt && !m0_we;
    m1_rvalid_d = m1_gnt && !m1_we;
    m0_rdata_d  = m0_rvalid_d ? mem_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? mem_rdata : m1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= 4'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port1_arbiter.sv
// tb/tb_mem_port1_arbiter.sv - scoreboard bench for mem_port1_arbiter (MAX_WAIT 4 and 0 builds)
module tb_mem_port1_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 64;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_we, m1_starved;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          n0_req, n0_we, n0_gnt, n0_rvalid;
  logic [AW-1:0] n0_adr;
  logic [DW-1:0] n0_wdata, n0_rdata;
  logic          n1_req, n1_we, n1_gnt, n1_rvalid;
  logic [AW-1:0] n1_adr;
  logic [DW-1:0] n1_wdata, n1_rdata;
  logic          n_mem_we, n_starved;
  logic [AW-1:0] n_mem_adr;
  logic [DW-1:0] n_mem_wdata;
  logic [DW-1:0] n_mem_rdata = '0;

  mem_port1_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .m1_starved(m1_starved)
  );

  mem_port1_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .m0_req(n0_req), .m0_we(n0_we), .m0_adr(n0_adr), .m0_wdata(n0_wdata),
    .m0_gnt(n0_gnt), .m0_rvalid(n0_rvalid), .m0_rdata(n0_rdata),
    .m1_req(n1_req), .m1_we(n1_we), .m1_adr(n1_adr), .m1_wdata(n1_wdata),
    .m1_gnt(n1_gnt), .m1_rvalid(n1_rvalid), .m1_rdata(n1_rdata),
    .mem_we(n_mem_we), .mem_adr(n_mem_adr), .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata),
    .m1_starved(n_starved)
  );

  // Memory seen by the DUT, and an independent copy updated only by predicted writes.
  logic [DW-1:0] fmem      [0:65535];
  logic [DW-1:0] model_mem [0:65535];
  assign mem_rdata = fmem[mem_adr];
  always @(posedge clk) if (mem_we) fmem[mem_adr] <= mem_wdata;

  int checks = 0;
  int errors = 0;
  int denied = 0;
  bit pushed0 = 0, pushed1 = 0, last_g0 = 0, last_g1 = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already set; predict, compare, update the model.
  task automatic step();
    bit st, w0, w1, g0, g1;
    @(negedge clk);
    chkw("m0 read backlog", 64'(q0.size()), 64'(pushed0));
    chkw("m1 read backlog", 64'(q1.size()), 64'(pushed1));
    st = (denied >= MAXW);
    w1 = m1_req && (!m0_req || st);
    w0 = m0_req && !w1;
    g0 = w0 && !rst;
    g1 = w1 && !rst;
    chk1("m0_gnt", m0_gnt, g0);
    chk1("m1_gnt", m1_gnt, g1);
    chk1("mem_we", mem_we, (g0 && m0_we) || (g1 && m1_we));
    chkw("mem_adr", 64'(mem_adr), 64'(w1 ? m1_adr : m0_adr));
    chkw("mem_wdata", mem_wdata, w1 ? m1_wdata : m0_wdata);
    chk1("m1_starved", m1_starved, st && m1_req);
    chk1("w0 n1_gnt", n1_gnt, n1_req && !rst);
    chk1("w0 n0_gnt", n0_gnt, n0_req && !n1_req && !rst);
    chk1("w0 n_starved", n_starved, n1_req);
    if (rst) begin
      if (pushed0) void'(q0.pop_back());
      if (pushed1) void'(q1.pop_back());
    end
    pushed0 = g0 && !m0_we;
    pushed1 = g1 && !m1_we;
    if (pushed0) q0.push_back(model_mem[m0_adr]);
    if (pushed1) q1.push_back(model_mem[m1_adr]);
    if (g0 && m0_we) model_mem[m0_adr] = m0_wdata;
    if (g1 && m1_we) model_mem[m1_adr] = m1_wdata;
    if (rst || g1 || !m1_req) denied = 0;
    else if (denied < MAXW) denied++;
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input int adr, input logic [DW-1:0] wd);
    m0_req = req; m0_we = we; m0_adr = AW'(adr); m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input int adr, input logic [DW-1:0] wd);
    m1_req = req; m1_we = we; m1_adr = AW'(adr); m1_wdata = wd;
  endtask

  // Monitor: runs just after the driver's negedge checks, pops on each rvalid.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m0_rvalid === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_rvalid: unexpected pulse rdata %0h at %0t", m0_rdata, $time);
        end else chkw("m0_rdata", m0_rdata, q0.pop_front());
      end
      if (m1_rvalid === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_rvalid: unexpected pulse rdata %0h at %0t", m1_rdata, $time);
        end else chkw("m1_rdata", m1_rdata, q1.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      fmem[i]      = {16'hC0DE, 16'(i), 32'(i * 7)};
      model_mem[i] = {16'hC0DE, 16'(i), 32'(i * 7)};
    end
    fmem[16]      = 64'hAA;
    model_mem[16] = 64'hAA;
    rst = 1'b1;
    set_m0(0, 0, 0, '0);
    set_m1(0, 0, 0, '0);
    n0_req = 0; n0_we = 0; n0_adr = '0; n0_wdata = '0;
    n1_req = 0; n1_we = 0; n1_adr = '0; n1_wdata = '0;
    @(posedge clk);
    #1;

    // Reset: requests present but nothing granted.
    step();
    set_m0(1, 0, 16'h0010, '0);
    set_m1(1, 0, 16'h0020, '0);
    n0_req = 1; n1_req = 1;
    step();
    chkw("m0_rdata after reset", m0_rdata, '0);
    chkw("m1_rdata after reset", m1_rdata, '0);
    rst = 1'b0;
    n0_req = 0; n1_req = 0;

    // Single m0 read of 0x0010 returning 0xAA.
    set_m1(0, 0, 0, '0);
    step();
    set_m0(0, 0, 0, '0);
    step();

    // Both requesting continuously: m0 x4 then forced m1.
    set_m0(1, 0, 16'h0005, '0);
    set_m1(1, 0, 16'h0006, '0);
    repeat (15) step();
    set_m0(0, 0, 0, '0);
    set_m1(0, 0, 0, '0);
    step();

    // Write-then-read hazard on 0x0040.
    set_m0(1, 1, 16'h0040, 64'h1234);
    set_m1(1, 0, 16'h0040, '0);
    step();
    set_m0(0, 0, 0, '0);
    step();
    set_m1(0, 0, 0, '0);
    step();

    // m1 burst writes then m0 readback.
    for (int i = 0; i < 8; i++) begin
      set_m1(1, 1, i, 64'hBEEF_0000 + 64'(i));
      step();
    end
    set_m1(0, 0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      set_m0(1, 0, i, '0);
      step();
    end
    set_m0(0, 0, 0, '0);
    step();

    // Reset right after an m1 read grant.
    set_m1(1, 0, 3, '0);
    step();
    rst = 1'b1;
    set_m0(1, 1, 7, 64'h5555);
    step();
    chkw("m1_rdata cleared by reset", m1_rdata, '0);
    rst = 1'b0;
    set_m0(0, 0, 0, '0);
    set_m1(0, 0, 0, '0);
    step();

    // MAX_WAIT = 0 build: m1 wins every cycle until it drops.
    n0_req = 1; n1_req = 1;
    repeat (6) step();
    n1_req = 0;
    step();
    n0_req = 0;
    step();

    // Randomized traffic; fields held while a request is pending.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (m0_req && !last_g0) begin
        if ($urandom_range(0, 9) == 0) m0_req = 1'b0;
      end else begin
        set_m0($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), {$urandom, $urandom});
      end
      if (m1_req && !last_g1) begin
        if ($urandom_range(0, 9) == 0) m1_req = 1'b0;
      end else begin
        set_m1($urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), {$urandom, $urandom});
      end
      step();
    end
    rst = 1'b0;
    set_m0(0, 0, 0, '0);
    set_m1(0, 0, 0, '0);
    repeat (3) step();
    chkw("m0 queue drained", 64'(q0.size()), 64'd0);
    chkw("m1 queue drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
